// File: rtl/m_bpred.sv
// Branch predictor: direct-mapped BTB with a saturating direction counter per entry.
// Ports:
//   w_clk, w_rst_n        clock, async active-low reset
//   w_flush               invalidate all entries at the edge (drops a same-edge update)
//   w_lk_en, w_lk_pc      lookup request; low enable holds the prediction outputs
//   r_hit/r_taken/r_tpc   registered prediction, one cycle after the lookup
//   w_upd_*               branch-resolve update port
//   r_nlk, r_nmis         free-running lookup and mispredict counters
module m_bpred #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_flush,
  input  logic              w_lk_en,
  input  logic [ADDR_W-1:0] w_lk_pc,
  output logic              r_hit,
  output logic              r_taken,
  output logic [ADDR_W-1:0] r_tpc,
  input  logic              w_upd_v,
  input  logic [ADDR_W-1:0] w_upd_pc,
  input  logic              w_upd_taken,
  input  logic [ADDR_W-1:0] w_upd_tpc,
  input  logic              w_upd_mis,
  output logic [31:0]       r_nlk,
  output logic [31:0]       r_nmis
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = {1'b1, {(CNT_W-1){1'b0}}};

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [ADDR_W-1:0]  r_tgt [ENTRIES];
  logic [CNT_W-1:0]   r_cnt [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_lk_hit;
  logic             w_upd_hit;
  logic             w_alloc;
  logic             w_tgt_we;
  logic             w_cnt_we;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_unused;

  // PC split: word-aligned index, tag directly above it.
  assign w_lk_idx  = w_lk_pc[IDX_W+1:2];
  assign w_lk_tag  = w_lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_upd_idx = w_upd_pc[IDX_W+1:2];
  assign w_upd_tag = w_upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Byte offset and high PC bits take no part in the prediction.
  assign w_unused = ^{w_lk_pc[1:0], w_lk_pc[ADDR_W-1:IDX_W+TAG_W+2],
                      w_upd_pc[1:0], w_upd_pc[ADDR_W-1:IDX_W+TAG_W+2]};

  assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Update decode: train on a hit, allocate weakly-taken on a taken miss.
  always_comb begin
    w_alloc   = 1'b0;
    w_tgt_we  = 1'b0;
    w_cnt_we  = 1'b0;
    w_cnt_nxt = r_cnt[w_upd_idx];
    if (w_upd_v && !w_flush) begin
      if (w_upd_hit) begin
        w_cnt_we = 1'b1;
        if (w_upd_taken) begin
          w_tgt_we = 1'b1;
          if (r_cnt[w_upd_idx] != CNT_MAX) w_cnt_nxt = r_cnt[w_upd_idx] + CNT_W'(1);
        end else if (r_cnt[w_upd_idx] != '0) begin
          w_cnt_nxt = r_cnt[w_upd_idx] - CNT_W'(1);
        end
      end else if (w_upd_taken) begin
        w_alloc   = 1'b1;
        w_tgt_we  = 1'b1;
        w_cnt_we  = 1'b1;
        w_cnt_nxt = CNT_WEAK;
      end
    end
  end

  // Valid bits: the only reset state in the array.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_valid <= '0;
    end else if (w_flush) begin
      r_valid <= '0;
    end else if (w_alloc) begin
      r_valid[w_upd_idx] <= 1'b1;
    end
  end

  // Payload arrays. A write landing while reset is asserted goes into an entry
  // whose valid bit is held clear, so it can never be observed.
  always_ff @(posedge w_clk) begin
    if (w_alloc)  r_tag[w_upd_idx] <= w_upd_tag;
    if (w_tgt_we) r_tgt[w_upd_idx] <= w_upd_tpc;
    if (w_cnt_we) r_cnt[w_upd_idx] <= w_cnt_nxt;
  end

  // Prediction outputs sample pre-update array contents (read-before-write).
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hit   <= 1'b0;
      r_taken <= 1'b0;
      r_tpc   <= '0;
    end else if (w_lk_en) begin
      r_hit   <= w_lk_hit;
      r_taken <= w_lk_hit && r_cnt[w_lk_idx][CNT_W-1];
      r_tpc   <= w_lk_hit ? r_tgt[w_lk_idx] : '0;
    end
  end

  // Performance counters; free-running, unaffected by flush.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_nlk  <= '0;
      r_nmis <= '0;
    end else begin
      if (w_lk_en)              r_nlk  <= r_nlk + 32'd1;
      if (w_upd_v && w_upd_mis) r_nmis <= r_nmis + 32'd1;
    end
  end

endmodule

// File: tb/tb_m_bpred.sv
// Testbench for m_bpred: behavioural BTB model checked every cycle, plus literal checks.
module tb_m_bpred;

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        w_flush = 1'b0;
  logic        w_lk_en = 1'b0;
  logic [31:0] w_lk_pc = '0;
  logic        r_hit;
  logic        r_taken;
  logic [31:0] r_tpc;
  logic        w_upd_v = 1'b0;
  logic [31:0] w_upd_pc = '0;
  logic        w_upd_taken = 1'b0;
  logic [31:0] w_upd_tpc = '0;
  logic        w_upd_mis = 1'b0;
  logic [31:0] r_nlk;
  logic [31:0] r_nmis;

  m_bpred dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_flush(w_flush),
    .w_lk_en(w_lk_en), .w_lk_pc(w_lk_pc),
    .r_hit(r_hit), .r_taken(r_taken), .r_tpc(r_tpc),
    .w_upd_v(w_upd_v), .w_upd_pc(w_upd_pc), .w_upd_taken(w_upd_taken),
    .w_upd_tpc(w_upd_tpc), .w_upd_mis(w_upd_mis),
    .r_nlk(r_nlk), .r_nmis(r_nmis)
  );

  always #5 w_clk = ~w_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  int unsigned lk_cnt  = 0;
  int unsigned mis_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: 16 entries, 8-bit tags, 2-bit counters.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int unsigned m_cnt   [16];
  bit          e_hit, e_taken;
  logic [31:0] e_tpc, e_nlk, e_nmis;

  function automatic int unsigned f_idx(input logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction
  function automatic int unsigned f_tag(input logic [31:0] pc);
    return (pc / 64) % 256;
  endfunction

  always @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      e_hit = 0; e_taken = 0; e_tpc = 0; e_nlk = 0; e_nmis = 0;
    end else begin
      int unsigned li, ui;
      bit uhit;
      if (w_lk_en) begin
        li      = f_idx(w_lk_pc);
        e_hit   = m_valid[li] && (m_tag[li] == f_tag(w_lk_pc));
        e_taken = e_hit && (m_cnt[li] >= 2);
        e_tpc   = e_hit ? m_tgt[li] : 32'h0;
        e_nlk   = e_nlk + 1;
      end
      if (w_upd_v && w_upd_mis) e_nmis = e_nmis + 1;
      if (w_flush) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else if (w_upd_v) begin
        ui   = f_idx(w_upd_pc);
        uhit = m_valid[ui] && (m_tag[ui] == f_tag(w_upd_pc));
        if (uhit && w_upd_taken) begin
          m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
          m_tgt[ui] = w_upd_tpc;
        end else if (uhit) begin
          m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
        end else if (w_upd_taken) begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = f_tag(w_upd_pc);
          m_tgt[ui]   = w_upd_tpc;
          m_cnt[ui]   = 2;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge w_clk) begin
    if (chk_on) begin
      chk("model_hit",   32'(r_hit),   32'(e_hit));
      chk("model_taken", 32'(r_taken), 32'(e_taken));
      chk("model_tpc",   r_tpc,  e_tpc);
      chk("model_nlk",   r_nlk,  e_nlk);
      chk("model_nmis",  r_nmis, e_nmis);
    end
  end

  // Applies one cycle of inputs; returns 2 time units after the consuming edge.
  task automatic drive(input bit lk, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utpc,
                       input bit um, input bit fl);
    w_lk_en = lk; w_lk_pc = lpc; w_upd_v = uv; w_upd_pc = upc;
    w_upd_taken = ut; w_upd_tpc = utpc; w_upd_mis = um; w_flush = fl;
    if (lk) lk_cnt++;
    if (uv && um) mis_cnt++;
    @(posedge w_clk);
    #2;
  endtask

  task automatic lookup(input logic [31:0] pc);
    drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic update(input logic [31:0] pc, input bit t, input logic [31:0] tpc, input bit m);
    drive(1'b0, 32'h0, 1'b1, pc, t, tpc, m, 1'b0);
  endtask

  task automatic expect_pred(input string name, input bit h, input bit t, input logic [31:0] tpc);
    chk({name, "_hit"},   32'(r_hit),   32'(h));
    chk({name, "_taken"}, 32'(r_taken), 32'(t));
    chk({name, "_tpc"},   r_tpc, tpc);
  endtask

  logic [31:0] pc_tab [4];

  initial begin
    pc_tab[0] = 32'h40; pc_tab[1] = 32'h440; pc_tab[2] = 32'h48; pc_tab[3] = 32'h104C;
    repeat (2) @(posedge w_clk);
    #2;
    w_rst_n = 1'b1;
    chk_on  = 1'b1;
    expect_pred("reset", 1'b0, 1'b0, 32'h0);
    chk("reset_nlk", r_nlk, 32'h0);

    // Cold lookups all miss.
    lookup(32'h40);   expect_pred("cold40", 1'b0, 1'b0, 32'h0);
    lookup(32'h80);   expect_pred("cold80", 1'b0, 1'b0, 32'h0);
    lookup(32'h1000); expect_pred("cold1000", 1'b0, 1'b0, 32'h0);
    chk("cold_nlk", r_nlk, 32'd3);

    // Allocate weakly taken.
    update(32'h40, 1'b1, 32'h20, 1'b1);
    lookup(32'h40); expect_pred("alloc", 1'b1, 1'b1, 32'h20);

    // Decrement saturates at 0, entry stays valid.
    repeat (3) update(32'h40, 1'b0, 32'h0, 1'b1);
    lookup(32'h40); expect_pred("sat_lo", 1'b1, 1'b0, 32'h20);
    update(32'h40, 1'b1, 32'h24, 1'b0);
    lookup(32'h40); expect_pred("cnt1", 1'b1, 1'b0, 32'h24);
    repeat (3) update(32'h40, 1'b1, 32'h20, 1'b0);
    lookup(32'h40); expect_pred("sat_hi", 1'b1, 1'b1, 32'h20);
    chk("nmis_a", r_nmis, 32'(mis_cnt));

    // Alias eviction; not-taken alias update leaves the entry alone.
    update(32'h40, 1'b1, 32'h20, 1'b0);
    update(32'h440, 1'b1, 32'h99C, 1'b1);
    lookup(32'h40);  expect_pred("alias_old", 1'b0, 1'b0, 32'h0);
    lookup(32'h440); expect_pred("alias_new", 1'b1, 1'b1, 32'h99C);
    update(32'h40, 1'b0, 32'h0, 1'b0);
    lookup(32'h440); expect_pred("alias_nt", 1'b1, 1'b1, 32'h99C);
    lookup(32'h40);  expect_pred("alias_nt_old", 1'b0, 1'b0, 32'h0);

    // Same-edge lookup and allocate: read-before-write.
    drive(1'b1, 32'h84, 1'b1, 32'h84, 1'b1, 32'h200, 1'b0, 1'b0);
    expect_pred("rbw_first", 1'b0, 1'b0, 32'h0);
    lookup(32'h84); expect_pred("rbw_next", 1'b1, 1'b1, 32'h200);

    // Stall: outputs and lookup count hold.
    repeat (3) drive(1'b0, 32'h440, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_pred("stall", 1'b1, 1'b1, 32'h200);
    chk("stall_nlk", r_nlk, 32'(lk_cnt));

    // Directed sweep over aliasing and distinct entries, model-checked.
    for (int i = 0; i < 24; i++)
      drive(1'b1, pc_tab[(i + 1) % 4], 1'b1, pc_tab[i % 4], ((i * 7) % 3) != 0,
            32'h1000 + 32'(i * 4), (i % 5) == 0, 1'b0);
    chk("sweep_nmis", r_nmis, 32'(mis_cnt));

    // Flush with update: same-edge lookup sees old contents, update dropped.
    update(32'h84, 1'b1, 32'h200, 1'b0);
    drive(1'b1, 32'h84, 1'b1, 32'h100, 1'b1, 32'h44, 1'b0, 1'b1);
    chk("flush_same_hit", 32'(r_hit), 32'd1);
    lookup(32'h84);  expect_pred("flush_84", 1'b0, 1'b0, 32'h0);
    lookup(32'h100); expect_pred("flush_100", 1'b0, 1'b0, 32'h0);
    lookup(32'h440); expect_pred("flush_440", 1'b0, 1'b0, 32'h0);
    chk("flush_nlk", r_nlk, 32'(lk_cnt));

    // Asynchronous reset pulse between edges.
    update(32'h40, 1'b1, 32'h20, 1'b1);
    lookup(32'h40); expect_pred("pre_rst", 1'b1, 1'b1, 32'h20);
    w_rst_n = 1'b0;
    #1;
    expect_pred("rst_pulse", 1'b0, 1'b0, 32'h0);
    chk("rst_nlk", r_nlk, 32'h0);
    chk("rst_nmis", r_nmis, 32'h0);
    #1;
    w_rst_n = 1'b1;
    lk_cnt = 0; mis_cnt = 0;
    lookup(32'h40); expect_pred("post_rst", 1'b0, 1'b0, 32'h0);
    chk("post_rst_nlk", r_nlk, 32'd1);

    @(negedge w_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_bpred.md
Name: m_bpred

Overview:
- Parametrised branch predictor for the next m_proc pipeline: direct-mapped BTB plus per-entry saturating counters.
- IF presents r_pc every cycle. The prediction returns registered one cycle later, matching the synchronous-read timing of m_memory, so it lines up with IfId_ir.
- The branch-resolve stage writes outcomes back through a single update port.
- Also keeps lookup and mispredict performance counters.

Parameters:
- IDX_W, 4: index bits; entries = 2**IDX_W.
- TAG_W, 8: tag bits stored per entry.
- CNT_W, 2: saturating counter width; CNT_W >= 2.
- ADDR_W, 32: PC and target width.

Ports:
- w_clk  in  1  rising-edge clock.
- w_rst_n  in  1  reset, asynchronous, active-low.
- w_flush  in  1  synchronous invalidate of all entries.
- w_lk_en  in  1  lookup enable; low = stall, hold outputs.
- w_lk_pc  in  ADDR_W  lookup PC.
- r_hit  out  1  registered: tag match and entry valid.
- r_taken  out  1  registered: r_hit and counter MSB == 1.
- r_tpc  out  ADDR_W  registered predicted target; 0 when r_hit == 0.
- w_upd_v  in  1  update strobe.
- w_upd_pc  in  ADDR_W  PC of the resolved branch.
- w_upd_taken  in  1  actual outcome.
- w_upd_tpc  in  ADDR_W  actual target.
- w_upd_mis  in  1  resolve stage detected a mispredict.
- r_nlk  out  32  count of enabled lookups.
- r_nmis  out  32  count of updates with w_upd_mis == 1.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] ignored.
- Storage per entry: valid bit, tag, target (ADDR_W), counter (CNT_W).
  - Valid bits are flops.
  - Tag, target and counter may be RAM-style and have no reset.
- Reset (w_rst_n == 0, asynchronous):
  - All valid bits = 0.
  - r_hit = r_taken = 0, r_tpc = 0, r_nlk = r_nmis = 0.
  - Reset asserted mid-operation discards any update in flight; nothing is written.
- Lookup, latency 1:
  - If w_lk_en is high at edge t, the outputs after edge t reflect array contents before any update at edge t (read-before-write).
  - If w_lk_en is low, r_hit, r_taken and r_tpc hold their values and r_nlk does not count.
- Update at edge t (w_upd_v == 1); e = entry[idx(w_upd_pc)].
  - e valid and tag match:
    - taken: counter = min(counter + 1, 2**CNT_W - 1); target = w_upd_tpc.
    - not taken: counter = max(counter - 1, 0); entry stays valid.
  - Miss (invalid entry, or valid entry with different tag):
    - taken: allocate (valid = 1, tag, target = w_upd_tpc, counter = 2**(CNT_W-1), weakly taken). This evicts any alias.
    - not taken: no change.
  - Counter arithmetic is unsigned and saturating; it never wraps.
- Flush (w_flush == 1): at the edge, all valid = 0.
  - Flush has priority over a simultaneous update; the update is dropped.
  - A lookup at the same edge still returns pre-flush contents.
- r_nlk increments per enabled lookup; r_nmis increments per update with w_upd_mis == 1.
  - Both are free-running 32-bit counters that wrap 0xFFFFFFFF -> 0.
  - Neither is cleared by flush.
- No combinational path from any input to any output.

Test Plan:
- Reset, then look up 0x40, 0x80, 0x1000 -> r_hit = 0, r_taken = 0, r_tpc = 0 each cycle; r_nlk = 3.
- Update pc = 0x40, taken, tpc = 0x20, then look up 0x40 -> r_hit = 1, r_taken = 1 (counter 2), r_tpc = 0x20.
- Three not-taken updates to 0x40 -> counter 2 -> 1 -> 0 -> 0; lookup gives r_hit = 1, r_taken = 0. Four taken updates -> counter saturates at 3, r_taken = 1.
- Alias: taken update 0x40 (tpc 0x20), then taken update 0x440 (same idx, tag differs, tpc 0x99C) -> lookup 0x40 misses; lookup 0x440 hits with r_tpc = 0x99C. Not-taken update to an alias leaves the entry unchanged.
- Same edge: lookup 0x40 with taken update 0x40 on a cold entry -> that lookup misses; the next lookup hits.
- Protocol edge cases:
  - Hold w_lk_en = 0 for 3 cycles -> outputs held, r_nlk unchanged.
  - Assert w_flush with an update -> all entries miss afterwards.
  - Pulse w_rst_n low between edges -> outputs 0 immediately, counters 0.
